// File: rtl/ro_sensor_receiver.sv
// ro_sensor_receiver
// Receiving end of the temporal thermal covert channel. Counts rising edges of a
// sensing ring oscillator over fixed clk windows. A hot die slows the RO, so a count
// below the latched threshold decodes as 1. Each window's result is offered to the
// host readout over a valid/ready handshake.
//
// Ports:
//   clk, rst                  single clock, synchronous active-high reset
//   ro_sensing_enable         run back-to-back measurements while high
//   ro_osc                    pre-divided RO output, asynchronous to clk
//   window_cycles             window length in clk cycles (0 acts as 1), latched per window
//   threshold                 decode threshold, latched per window
//   ro_sensing_counter_value  edge count of the last completed window
//   bit_out                   decoded bit of the last completed window
//   overflow                  last window's count saturated
//   sample_index              number of samples accepted by the consumer
//   sample_valid              sample available
//   sample_ready              consumer accepts the sample
`timescale 1ns / 1ps

module ro_sensor_receiver #(
   parameter int unsigned COUNT_W = 64,
   parameter int unsigned WIN_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ro_sensing_enable,
   input  logic               ro_osc,
   input  logic [WIN_W-1:0]   window_cycles,
   input  logic [COUNT_W-1:0] threshold,
   output logic [COUNT_W-1:0] ro_sensing_counter_value,
   output logic               bit_out,
   output logic               overflow,
   output logic [WIN_W-1:0]   sample_index,
   output logic               sample_valid,
   input  logic               sample_ready
);

   typedef enum logic [1:0] {StIdle, StMeasure, StHold} state_e;

   state_e r_state;
   state_e w_state_next;

   logic               r_s1, r_s2, r_s3;
   logic [WIN_W-1:0]   r_remaining;
   logic [COUNT_W-1:0] r_thresh;
   logic [COUNT_W-1:0] r_count;
   logic               r_sat;

   logic               w_edge;
   logic               w_start;
   logic               w_last;
   logic               w_handshake;
   logic               w_all_ones;
   logic [WIN_W-1:0]   w_win_len;
   logic [COUNT_W-1:0] w_count_next;
   logic               w_sat_next;

   assign w_edge       = r_s2 & ~r_s3;
   assign w_last       = (r_remaining == WIN_W'(1));
   assign w_handshake  = sample_valid & sample_ready;
   assign w_all_ones   = &r_count;
   assign w_win_len    = (window_cycles == '0) ? WIN_W'(1) : window_cycles;
   // Count includes this cycle's edge; it sticks at all-ones and flags the window.
   assign w_count_next = (w_edge && !w_all_ones) ? r_count + COUNT_W'(1) : r_count;
   assign w_sat_next   = r_sat | (w_edge & w_all_ones);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      case (r_state)
         StIdle: begin
            if (ro_sensing_enable) begin
               w_state_next = StMeasure;
               w_start      = 1'b1;
            end
         end
         StMeasure: begin
            // Losing enable aborts the window without producing a sample.
            if (!ro_sensing_enable) begin
               w_state_next = StIdle;
            end else if (w_last) begin
               w_state_next = StHold;
            end
         end
         StHold: begin
            if (w_handshake) begin
               if (ro_sensing_enable) begin
                  w_state_next = StMeasure;
                  w_start      = 1'b1;
               end else begin
                  w_state_next = StIdle;
               end
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1                     <= 1'b0;
         r_s2                     <= 1'b0;
         r_s3                     <= 1'b0;
         r_remaining              <= '0;
         r_thresh                 <= '0;
         r_count                  <= '0;
         r_sat                    <= 1'b0;
         ro_sensing_counter_value <= '0;
         bit_out                  <= 1'b0;
         overflow                 <= 1'b0;
         sample_index             <= '0;
         sample_valid             <= 1'b0;
      end else begin
         r_s1 <= ro_osc;
         r_s2 <= r_s1;
         r_s3 <= r_s2;

         if (w_start) begin
            r_remaining <= w_win_len;
            r_thresh    <= threshold;
            r_count     <= '0;
            r_sat       <= 1'b0;
         end else if (r_state == StMeasure && ro_sensing_enable) begin
            r_remaining <= r_remaining - WIN_W'(1);
            r_count     <= w_count_next;
            r_sat       <= w_sat_next;
            if (w_last) begin
               ro_sensing_counter_value <= w_count_next;
               bit_out                  <= (w_count_next < r_thresh);
               overflow                 <= w_sat_next;
               sample_valid             <= 1'b1;
            end
         end else if (r_state == StIdle) begin
            r_count <= '0;
            r_sat   <= 1'b0;
         end

         // Only reachable in StHold, so it never collides with the set above.
         if (w_handshake) begin
            sample_valid <= 1'b0;
            sample_index <= sample_index + WIN_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ro_sensor_receiver.sv
// Bench for ro_sensor_receiver. Two instances share all stimulus: a 64-bit counter and a
// 4-bit counter that exercises saturation. A cycle-indexed model records the sampled
// ro_osc history and derives each window's count by counting rising transitions.
`timescale 1ns / 1ps

module tb_ro_sensor_receiver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        ro = 1'b0;
   logic        ready = 1'b0;
   logic [31:0] wc = '0;
   logic [63:0] thr = '0;

   logic [63:0] a_cnt;
   logic        a_bit, a_ovf, a_valid;
   logic [31:0] a_idx;
   logic [3:0]  b_cnt;
   logic        b_bit, b_ovf, b_valid;
   logic [31:0] b_idx;

   int n_vec = 0;
   int n_miss = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   ro_sensor_receiver #(.COUNT_W(64), .WIN_W(32)) u_dut64 (
      .clk                      (clk),
      .rst                      (rst),
      .ro_sensing_enable        (en),
      .ro_osc                   (ro),
      .window_cycles            (wc),
      .threshold                (thr),
      .ro_sensing_counter_value (a_cnt),
      .bit_out                  (a_bit),
      .overflow                 (a_ovf),
      .sample_index             (a_idx),
      .sample_valid             (a_valid),
      .sample_ready             (ready)
   );

   ro_sensor_receiver #(.COUNT_W(4), .WIN_W(32)) u_dut4 (
      .clk                      (clk),
      .rst                      (rst),
      .ro_sensing_enable        (en),
      .ro_osc                   (ro),
      .window_cycles            (wc),
      .threshold                (thr[3:0]),
      .ro_sensing_counter_value (b_cnt),
      .bit_out                  (b_bit),
      .overflow                 (b_ovf),
      .sample_index             (b_idx),
      .sample_valid             (b_valid),
      .sample_ready             (ready)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ro_osc generator: square wave of ro_period clk cycles, or a static level.
   int   ro_period = 0;
   logic ro_level  = 1'b0;
   int   ro_ph     = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (ro_period > 1) begin
            ro_ph = (ro_ph + 1) % ro_period;
            ro    = (ro_ph < ro_period / 2);
         end else begin
            ro = ro_level;
         end
      end
   end

   // Model. hist[n] is ro_osc as seen at posedge n (0 while in reset). An edge counts
   // at posedge n when the sampled value rose between posedges n-3 and n-2.
   bit          hist [32768];
   bit          in_win = 1'b0;
   bit          pending = 1'b0;
   int          w_start = 0;
   int          w_len = 0;
   logic [63:0] w_thr = '0;
   logic [63:0] e_raw = '0;
   logic [3:0]  e_cnt4 = '0;
   logic        e_ovf4 = 1'b0;
   logic        e_bit64 = 1'b0;
   logic        e_bit4 = 1'b0;
   logic [31:0] e_idx = '0;

   function automatic logic [63:0] count_edges(input int a, input int b);
      logic [63:0] n = '0;
      for (int k = a; k <= b; k++) begin
         if (k >= 3 && hist[k-2] && !hist[k-3]) n = n + 64'd1;
      end
      return n;
   endfunction

   task automatic open_window(input int s);
      in_win  = 1'b1;
      w_start = s;
      w_len   = (wc == 32'd0) ? 1 : int'(wc);
      w_thr   = thr;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         hist[cyc] = rst ? 1'b0 : ro;
         if (rst) begin
            in_win  = 1'b0;
            pending = 1'b0;
            e_raw   = '0;
            e_cnt4  = '0;
            e_ovf4  = 1'b0;
            e_bit64 = 1'b0;
            e_bit4  = 1'b0;
            e_idx   = '0;
         end else if (pending) begin
            if (ready) begin
               pending = 1'b0;
               e_idx   = e_idx + 32'd1;
               if (en) open_window(cyc + 1);
            end
         end else if (in_win) begin
            if (!en) begin
               in_win = 1'b0;
            end else if (cyc == w_start + w_len - 1) begin
               e_raw   = count_edges(w_start, cyc);
               e_cnt4  = (e_raw > 64'd15) ? 4'hF : e_raw[3:0];
               e_ovf4  = (e_raw > 64'd15);
               e_bit64 = (e_raw < w_thr);
               e_bit4  = (e_cnt4 < w_thr[3:0]);
               pending = 1'b1;
               in_win  = 1'b0;
            end
         end else if (en) begin
            open_window(cyc + 1);
         end
         cyc++;
      end
   end

   // Compare both instances against the model every cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (cyc > 0) begin
            check("cnt64", a_cnt, e_raw);
            check("bit64", 64'(a_bit), 64'(e_bit64));
            check("ovf64", 64'(a_ovf), 64'(0));
            check("idx64", 64'(a_idx), 64'(e_idx));
            check("valid64", 64'(a_valid), 64'(pending));
            check("cnt4", 64'(b_cnt), 64'(e_cnt4));
            check("bit4", 64'(b_bit), 64'(e_bit4));
            check("ovf4", 64'(b_ovf), 64'(e_ovf4));
            check("idx4", 64'(b_idx), 64'(e_idx));
            check("valid4", 64'(b_valid), 64'(pending));
         end
      end
   end

   task automatic step(input int k);
      repeat (k) @(negedge clk);
   endtask

   // Returns cyc at the first negedge with sample_valid high, or -1 on timeout.
   task automatic wait_valid(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (a_valid) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL wait_valid: no sample_valid within %0d cycles (cycle %0d)", budget, cyc);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   int t, at, h;

   initial begin
      // Reset for two cycles with ro_osc toggling.
      ro_period = 2;
      step(1);
      check("rst_cnt64", a_cnt, 64'(0));
      check("rst_valid", 64'(a_valid), 64'(0));
      check("rst_idx", 64'(a_idx), 64'(0));
      check("rst_cnt4", 64'(b_cnt), 64'(0));
      step(1);
      rst = 1'b0;
      step(10);
      check("idle_valid", 64'(a_valid), 64'(0));

      // Basic count: period 10 over 100 cycles gives exactly 10 edges.
      ro_period = 10;
      step(20);
      wc = 32'd100; thr = 64'd20; ready = 1'b1; en = 1'b1;
      t = cyc;
      wait_valid(200, at);
      check("basic_latency", 64'(at), 64'(t + 101));
      check("basic_cnt", a_cnt, 64'(10));
      check("basic_bit", 64'(a_bit), 64'(1));
      en = 1'b0;
      step(1);
      check("basic_idx", 64'(a_idx), 64'(1));

      // Threshold decode; a mid-window threshold change only affects the next window.
      ro_period = 4;
      step(20);
      thr = 64'd20; en = 1'b1;
      step(50);
      thr = 64'd26;
      wait_valid(200, at);
      check("thr_cnt_a", a_cnt, 64'(25));
      check("thr_bit_a", 64'(a_bit), 64'(0));
      wait_valid(200, at);
      check("thr_cnt_b", a_cnt, 64'(25));
      check("thr_bit_b", 64'(a_bit), 64'(1));
      en = 1'b0;
      step(1);

      // Backpressure: sample held for 50 cycles, next window starts after the handshake.
      ready = 1'b0;
      ro_period = 3;
      step(20);
      thr = 64'd0; en = 1'b1;
      wait_valid(200, at);
      step(50);
      check("bp_valid_held", 64'(a_valid), 64'(1));
      check("bp_idx_held", 64'(a_idx), 64'(3));
      ready = 1'b1;
      h = cyc;
      wait_valid(200, at);
      check("bp_restart", 64'(at), 64'(h + 101));
      en = 1'b0;
      step(1);
      check("bp_idx", 64'(a_idx), 64'(5));

      // Abort at window cycle 40.
      ro_period = 0; ro_level = 1'b1;
      en = 1'b1;
      step(40);
      en = 1'b0;
      step(150);
      check("abort_valid", 64'(a_valid), 64'(0));
      check("abort_idx", 64'(a_idx), 64'(5));

      // Zero-length window acts as one cycle; ro_osc static high gives no edges.
      wc = 32'd0; ready = 1'b0; en = 1'b1;
      t = cyc;
      wait_valid(10, at);
      check("zero_latency", 64'(at), 64'(t + 2));
      check("zero_cnt", a_cnt, 64'(0));
      en = 1'b0; ready = 1'b1;
      step(1);
      check("zero_idx", 64'(a_idx), 64'(6));

      // Saturation in the 4-bit instance, then a quiet window clears the flag.
      ro_level = 1'b0; ro_period = 2;
      step(20);
      wc = 32'd64; thr = 64'd0; en = 1'b1;
      step(56);
      ro_period = 0;
      wait_valid(100, at);
      check("sat_cnt4", 64'(b_cnt), 64'(15));
      check("sat_ovf4", 64'(b_ovf), 64'(1));
      wait_valid(100, at);
      check("quiet_cnt4", 64'(b_cnt), 64'(0));
      check("quiet_ovf4", 64'(b_ovf), 64'(0));
      check("quiet_cnt64", a_cnt, 64'(0));
      en = 1'b0;
      step(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/ro_sensor_receiver.md
# ro_sensor_receiver

Receiving end of the temporal thermal covert channel: the counterpart to the heater, which toggles RO heating on the sending side. The block measures the frequency of a sensing ring oscillator over fixed windows, so the RO count tracks local die temperature. Each window yields a 64-bit count and a decoded channel bit, delivered through a valid/ready handshake to the host readout logic in the Part Two sensor role.

## Interface

Parameters:
- `COUNT_W`, 64: width of edge counter and threshold; matches the heater-side counter width.
- `WIN_W`, 32: width of window length, window counter and sample index.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `ro_sensing_enable` in 1: run measurements while high.
- `ro_osc` in 1: sensing RO output, pre-divided to below `clk`/2, asynchronous to `clk`.
- `window_cycles` in `WIN_W`: window length in `clk` cycles; latched at window start.
- `threshold` in `COUNT_W`: decode threshold; latched at window start.
- `ro_sensing_counter_value` out `COUNT_W`: edge count of the last completed window.
- `bit_out` out 1: decoded bit for the last window.
- `overflow` out 1: last window's count saturated.
- `sample_index` out `WIN_W`: number of samples accepted so far.
- `sample_valid` out 1: sample available.
- `sample_ready` in 1: consumer accepts sample.

## Operation

- **Synchronizer.** `ro_osc` passes through 2 flops, then a third flop for edge detect. A rising edge is `s2 & ~s3`. Only rising edges are counted.
- **IDLE.**
  - Counter is cleared and the edges input is ignored.
  - When `ro_sensing_enable` is high, latch `window_cycles` into `remaining` and latch `threshold`, then go to MEASURE.
  - A `window_cycles` value of 0 is treated as 1.
- **MEASURE.**
  - Each cycle: `remaining` decrements, and a detected edge increments `count`.
  - `count` saturates at all-ones, with a sticky per-window saturation flag.
  - When `remaining` == 1, the edge from that cycle is included, and the following are registered:
    - `ro_sensing_counter_value` = final count.
    - `bit_out` = (final count < latched threshold), because a hotter RO runs slower, so heater on gives 1.
    - `overflow` = saturation flag.
    - `sample_valid` = 1.
  - Then go to HOLD.
  - If `ro_sensing_enable` drops during MEASURE: abort, go to IDLE, no sample is produced, and all outputs keep their previous values.
- **HOLD.**
  - Edges are discarded (dead time).
  - Outputs are stable while `sample_valid` is high.
  - On `sample_valid & sample_ready`: clear `sample_valid` and increment `sample_index` (wraps from all-ones to 0).
  - In the same cycle, choose the next state:
    - `ro_sensing_enable` high: re-latch `window_cycles` and `threshold`, then go to MEASURE.
    - Otherwise: go to IDLE.
  - Dropping enable in HOLD does not discard the pending sample; it waits for ready.
- **Reset.**
  - State is IDLE.
  - All outputs are 0: count, `bit_out`, `overflow`, `sample_index`, `sample_valid`.
  - Synchronizer flops and internal counters are 0.
  - Reset in any state, including mid-window, discards the partial window.

## Timing

- Enable sampled high in IDLE at cycle t: MEASURE covers cycles t+1..t+W, where W is the latched window.
- `sample_valid` rises at t+W+1.
- `ro_osc` to edge-detected latency: 3 cycles. Edges arriving within 3 cycles of the window end land in the next window, or are lost if HOLD is entered.
- Handshake at cycle h with enable high: the next window covers h+1..h+W. Back-to-back period is W+1 cycles plus any ready stall.
- `sample_ready` is ignored while `sample_valid` is 0. `sample_valid` never drops without a handshake except on `rst`.
- Count arithmetic is unsigned; comparison is unsigned across the full `COUNT_W`.

## Test plan

- **Reset values:** assert `rst` for 2 cycles with `ro_osc` toggling. All outputs read 0 and `sample_valid` stays 0 while enable is low.
- **Basic count:**
  - Stimulus: `window_cycles`=100, `ro_osc` period 10 clk, `threshold`=20, `sample_ready`=1.
  - Required response: `ro_sensing_counter_value`=10 (±1 for sync phase), `bit_out`=1, `sample_valid` at t+101, `sample_index`=1 after the handshake.
- **Threshold decode:**
  - Stimulus: same window, `ro_osc` period 4, `threshold`=20.
  - Required response: count 25, `bit_out`=0. Then set `threshold`=26 mid-window: the current bit stays 0, and the next window gives 1.
- **Backpressure:**
  - Stimulus: `sample_ready`=0 for 50 cycles after valid while `ro_osc` toggles.
  - Required response: outputs held, no new window starts, and the next window begins the cycle after ready.
- **Abort and zero window:**
  - Stimulus: drop enable at window cycle 40.
  - Required response: no `sample_valid`, `sample_index` unchanged, IDLE.
  - Stimulus: `window_cycles`=0 with `ro_osc` held high.
  - Required response: a 1-cycle window, count 0, valid at t+2.
- **Saturation:** with `COUNT_W`=4, `ro_osc` period 2 and a window of 64, count reads 15 and `overflow`=1. The following window with `ro_osc` idle gives count 0 and `overflow`=0.
